// File: rtl/burst_mem_responder.sv
// Four-beat 64-bit burst memory responder backed by a 2^ADDR_BITS x 256-bit line store.
// Optional protocol checker: define BURST_MEM_PROTO_CHECK_EN to build the sticky proto_err logic.
module burst_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err,
  output logic [1:0]  o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [CW-1:0]          r_cnt, w_cnt_next;
  logic [1:0]             r_beat, w_beat_next;
  logic                   r_op_wr, w_op_wr_next;
  logic [ADDR_BITS-1:0]   r_idx, w_idx_next;
  logic                   r_resp, w_resp_next;
  logic [63:0]            r_rdata, w_rdata_next;
  logic                   w_accept;
  logic                   w_mem_we;
  logic [ADDR_BITS-1:0]   w_idx_in;
  logic [ADDR_BITS+1:0]   w_rd_addr;

  // Store is organised as 64-bit beats addressed by {line index, beat}.
  logic [63:0] r_mem [0:4*DEPTH-1];

  assign w_accept = mem_read ^ mem_write;
  assign w_idx_in = mem_addr[5+ADDR_BITS-1:5];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_beat_next  = r_beat;
    w_op_wr_next = r_op_wr;
    w_idx_next   = r_idx;
    w_resp_next  = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_wr_next = mem_write;
          w_idx_next   = w_idx_in;
          w_beat_next  = 2'd0;
          if (LATENCY == 0) begin
            w_state_next = S_BURST;
            w_resp_next  = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CW'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_next = S_BURST;
          w_resp_next  = 1'b1;
          w_beat_next  = 2'd0;
        end
      end
      S_BURST: begin
        w_mem_we = r_op_wr;
        if (r_beat == 2'd3) begin
          w_state_next = S_DONE;
        end else begin
          w_beat_next = r_beat + 2'd1;
          w_resp_next = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_beat_next  = 2'd0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read data for the beat being entered is fetched one cycle ahead so the output stays registered.
  assign w_rd_addr    = {w_idx_next, w_beat_next};
  assign w_rdata_next = (w_resp_next && !w_op_wr_next) ? r_mem[w_rd_addr] : 64'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= 2'd0;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_resp  <= 1'b0;
      r_rdata <= 64'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_beat  <= w_beat_next;
      r_op_wr <= w_op_wr_next;
      r_idx   <= w_idx_next;
      r_resp  <= w_resp_next;
      r_rdata <= w_rdata_next;
    end
  end

  // No reset on the store; a reset mid-write keeps only the beats already committed.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[{r_idx, r_beat}] <= mem_wdata;
    end
  end

  assign mem_resp    = r_resp;
  assign mem_rdata   = r_rdata;
  assign o_dbg_state = r_state;

`ifdef BURST_MEM_PROTO_CHECK_EN
  logic        r_proto_err;
  logic [26:0] r_addr_hi;
  logic        w_busy;
  logic        w_req_bad;
  logic        w_viol;
  logic        w_unused_addr;

  assign w_unused_addr = ^mem_addr[4:0];
  assign w_busy        = (r_state == S_WAIT) || (r_state == S_BURST);
  assign w_req_bad     = r_op_wr ? !(mem_write && !mem_read) : !(mem_read && !mem_write);

  always_comb begin
    w_viol = 1'b0;
    if (mem_read && mem_write) w_viol = 1'b1;
    if (w_busy && (w_req_bad || (mem_addr[31:5] != r_addr_hi))) w_viol = 1'b1;
    if ((r_state == S_BURST) && r_op_wr && $isunknown(mem_wdata)) w_viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
      r_addr_hi   <= 27'd0;
    end else begin
      if (w_viol) r_proto_err <= 1'b1;
      if ((r_state == S_IDLE) && w_accept) r_addr_hi <= mem_addr[31:5];
    end
  end

  assign proto_err = r_proto_err;
`else
  logic w_unused_addr;

  assign w_unused_addr = ^{mem_addr[31:5+ADDR_BITS], mem_addr[4:0]};
  assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: shadow line model feeds an expected-beat queue checked by a monitor.
module tb_burst_mem_responder;

  localparam int LAT = 4;
  localparam int AB  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [63:0] mem_wdata = 64'd0;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;
  logic [1:0]  o_dbg_state;

  burst_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .proto_err(proto_err), .o_dbg_state(o_dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [63:0]  exp_q[$];
  logic [255:0] model_mem [0:(1<<AB)-1];
  bit   mon_en = 1'b0;
  bit   cur_rd = 1'b0;
  logic exp_proto = 1'b0;
  int   acc_edge = 0;

`ifdef BURST_MEM_PROTO_CHECK_EN
  localparam logic PROTO_ON = 1'b1;
`else
  localparam logic PROTO_ON = 1'b0;
`endif

  // scoreboard/monitor, sampled just after each rising edge
  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (mon_en) begin
      checks++;
      if (proto_err !== exp_proto) begin
        failures++;
        $display("FAIL proto_err cyc=%0d got=%b exp=%b", cyc, proto_err, exp_proto);
      end
      if (mem_resp === 1'b1 && cur_rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rdata_extra cyc=%0d got=%h exp=none", cyc, mem_rdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_rdata !== e) begin
            failures++;
            $display("FAIL rdata_beat cyc=%0d got=%h exp=%h", cyc, mem_rdata, e);
          end
        end
      end else if (mem_resp !== 1'b1) begin
        checks++;
        if (mem_rdata !== 64'd0) begin
          failures++;
          $display("FAIL rdata_idle cyc=%0d got=%h exp=0", cyc, mem_rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Driver tasks: all are entered and left just after a falling edge.
  // extra=1 when the request is raised during DONE, so acceptance is one edge later.
  task automatic start_req(input bit wr, input logic [31:0] addr, input logic [255:0] line,
                           input int extra);
    logic [AB-1:0] idx;
    idx       = addr[AB+4:5];
    mem_addr  = addr;
    mem_write = wr;
    mem_read  = !wr;
    mem_wdata = wr ? line[63:0] : 64'd0;
    cur_rd    = !wr;
    acc_edge  = cyc + 1 + extra;
    if (!wr) for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[idx][64*k +: 64]);
  endtask

  // Beat k is visible at the falling edge after rising edge acc_edge+LAT+k.
  task automatic finish_req(input bit wr, input logic [255:0] line, input int rst_beat);
    int k;
    int waited;
    bit hit_rst;
    logic [AB-1:0] idx;
    k = 0; waited = 0; hit_rst = 1'b0;
    idx = mem_addr[AB+4:5];
    while (k < 4 && waited < 64 && !hit_rst) begin
      @(negedge clk);
      waited++;
      if (mem_resp === 1'b1) begin
        if (k == 0) begin
          checks++;
          if (cyc != acc_edge + LAT) begin
            failures++;
            $display("FAIL first_beat_cycle got=%0d exp=%0d", cyc, acc_edge + LAT);
          end
        end
        if (k == rst_beat) begin
          rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; cur_rd = 1'b0;
          hit_rst = 1'b1;
        end else begin
          if (wr) begin
            mem_wdata = line[64*k +: 64];
            model_mem[idx][64*k +: 64] = line[64*k +: 64];
          end
          k++;
        end
      end else if (k > 0) begin
        checks++; failures++;
        $display("FAIL beat_gap cyc=%0d got_resp=%b exp_resp=1 beat=%0d", cyc, mem_resp, k);
        k = 4;
      end
    end
    if (!hit_rst) begin
      checks++;
      if (k < 4) begin
        failures++;
        $display("FAIL resp_timeout got_beats=%0d exp_beats=4", k);
      end
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || o_dbg_state !== 2'd3) begin
        failures++;
        $display("FAIL done_cycle got_resp=%b got_state=%0d exp_resp=0 exp_state=3", mem_resp, o_dbg_state);
      end
    end
  endtask

  task automatic idle_req();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] line);
    start_req(wr, addr, line, 0);
    finish_req(wr, line, -1);
    idle_req();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (mem_resp !== 1'b0 || mem_rdata !== 64'd0 || proto_err !== 1'b0 || o_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values got=%b/%h/%b/%0d exp=0/0/0/0", mem_resp, mem_rdata, proto_err, o_dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0) begin
        failures++;
        $display("FAIL idle_resp cyc=%0d got=%b exp=0", cyc, mem_resp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [255:0] line;
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 32'h0000_0040, line);
    run_txn(1'b0, 32'h0000_0040, '0);
  endtask

  task automatic test_alias();
    run_txn(1'b1, 32'h0000_8020, rand_line());
    run_txn(1'b0, 32'h0000_0020, '0);
  endtask

  task automatic test_back_to_back();
    logic [255:0] l2;
    int a1;
    l2 = rand_line();
    run_txn(1'b1, 32'h0000_0100, rand_line());
    start_req(1'b0, 32'h0000_0100, '0, 0);
    a1 = acc_edge;
    finish_req(1'b0, '0, -1);
    start_req(1'b1, 32'h0000_0120, l2, 1);
    checks++;
    if (acc_edge != a1 + LAT + 6) begin
      failures++;
      $display("FAIL b2b_accept got=%0d exp=%0d", acc_edge, a1 + LAT + 6);
    end
    finish_req(1'b1, l2, -1);
    idle_req();
    run_txn(1'b0, 32'h0000_0120, '0);
  endtask

  task automatic test_reset_mid();
    logic [255:0] l_new;
    l_new = rand_line();
    run_txn(1'b1, 32'h0000_0200, rand_line());
    start_req(1'b1, 32'h0000_0200, l_new, 0);
    finish_req(1'b1, l_new, 2);
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0 || o_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid got_resp=%b got_state=%0d exp=0/0", mem_resp, o_dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_0200, '0);
  endtask

  // Random write followed by a read of the same line raised during DONE.
  task automatic test_random();
    logic [255:0] l;
    logic [31:0]  a;
    for (int i = 0; i < 6; i++) begin
      l = rand_line();
      a = {$urandom_range(0, 31), 22'd0} | (32'($urandom_range(0, (1<<AB)-1)) << 5)
          | 32'($urandom_range(0, 31));
      start_req(1'b1, a, l, 0);
      finish_req(1'b1, l, -1);
      start_req(1'b0, a, '0, 1);
      finish_req(1'b0, '0, -1);
      idle_req();
    end
  endtask

  task automatic test_proto_both();
    mem_addr  = 32'h0000_0300;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    exp_proto = PROTO_ON;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_resp !== 1'b0 || o_dbg_state !== 2'd0) begin
        failures++;
        $display("FAIL both_high_started got_resp=%b got_state=%0d exp=0/0", mem_resp, o_dbg_state);
      end
    end
    idle_req();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_proto = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_proto_both();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Synthesizable responder for the 64-bit, four-beat burst memory protocol that the `mp4` core's `pmem_*` ports initiate. It stands in for physical memory on FPGA builds and in standalone cache-hierarchy benches. It holds a backing array of 256-bit lines and answers one full-line read or write per request. Programmable access latency is followed by four consecutive `mem_resp` beats.

## Interface
- `ADDR_BITS`, default 10: line-index width; backing store holds 2^ADDR_BITS lines of 256 bits.
- `LATENCY`, default 4: idle cycles between request acceptance and first beat; 0 is legal.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  line read request; held high by initiator until the last beat.
- `mem_write`  in  1  line write request; held high by initiator until the last beat.
- `mem_addr`  in  32  byte address; bits [4:0] ignored.
- `mem_wdata`  in  64  write beat; must be valid in every cycle `mem_resp`=1 during a write.
- `mem_rdata`  out  64  read beat; valid when `mem_resp`=1 during a read.
- `mem_resp`  out  1  beat strobe; high for exactly 4 consecutive cycles per transaction.
- `proto_err`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- States: IDLE, WAIT, BURST, DONE.
- Line index = `mem_addr[5+ADDR_BITS-1:5]`. Upper address bits alias, so the index wraps modulo 2^ADDR_BITS.
- IDLE: accept when `mem_read ^ mem_write`. Latch op, index, and 0 into beat counter. If LATENCY=0, go to BURST; else load latency counter with LATENCY and go to WAIT.
- IDLE with both `mem_read` and `mem_write` high: not accepted; stay IDLE.
- WAIT: decrement counter each cycle; go to BURST on the cycle counter reaches 1.
- BURST: `mem_resp`=1 for beats 0..3, and beat k covers line bits [64k+63:64k].
  - Read: `mem_rdata` drives beat k of the latched line.
  - Write: beat k of the array is written from `mem_wdata` on the edge ending that beat.
  - After beat 3, go to DONE.
- Once accepted, a transaction always completes all 4 beats. Request level, address changes and `mem_wdata` timing are not rechecked; the latched index is used throughout.
- DONE: one cycle, `mem_resp`=0, requests ignored. This gives the initiator time to drop its request. Then go to IDLE.
- Back-to-back: a request still high in the cycle after DONE is treated as a new transaction.
- Backing array has no reset; contents are undefined at power-up. Reset mid-transaction returns to IDLE, and a partially written line keeps the beats already committed.

## Timing
- Reset values: `mem_resp`=0, `mem_rdata`=0, `proto_err`=0, state IDLE, counters 0.
- Let cycle A be the edge on which the request is accepted in IDLE.
  - Beats occupy cycles A+LATENCY+1 through A+LATENCY+4.
  - DONE is cycle A+LATENCY+5; the earliest next acceptance is A+LATENCY+6.
- Transaction occupancy: LATENCY+6 cycles from acceptance to the next acceptance.
- `mem_resp` and `mem_rdata` are registered outputs with no combinational path from inputs.
- `mem_rdata` is 0 whenever `mem_resp`=0.
- A read issued after a write to the same line returns the new data. Write-then-read with no gap is legal.

## Configuration
- `BURST_MEM_PROTO_CHECK_EN` defined: `proto_err` is set, and held until `rst`, on any of the following:
  - `mem_read` and `mem_write` both high in any cycle;
  - request dropped or switched in WAIT or BURST;
  - `mem_addr[31:5]` changed in WAIT or BURST;
  - `mem_wdata` containing X/Z during a write beat (simulation only).
- `BURST_MEM_PROTO_CHECK_EN` undefined: `proto_err` is tied to 0 and no check logic is built. Transaction behaviour is identical in both builds.

## Test plan
- Reset, then idle for 10 cycles -> `mem_resp`=0, `mem_rdata`=0 and `proto_err`=0 throughout.
- LATENCY=4: write line 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x0000_0040.
  - `mem_resp` high on cycles A+5..A+8 for each transaction.
  - Read returns the four beats in the same order.
- Alias/wrap with ADDR_BITS=10: write 0x0000_8020, then read 0x0000_0020 -> same line data returned.
- Back-to-back: read of 0x100 held through DONE, followed immediately by a write to 0x120.
  - Second acceptance occurs at cycle A+LATENCY+6.
  - No extra `mem_resp` cycles appear.
- `rst` asserted at beat 2 of a write to 0x200, then line 0x200 read back.
  - `mem_resp`=0 on the next cycle.
  - Beats 0..1 hold the new data; beats 2..3 hold the old contents.
- Macro defined: assert `mem_read` and `mem_write` together -> `proto_err`=1 next cycle, no transaction starts, and the flag holds until `rst`. Macro undefined: same stimulus leaves `proto_err`=0.
